noc_out_arbiter: RTL and testbench
==================================

# noc_out_arbiter

Per-output-port round-robin arbiter for the NoC router. It shares one router output port among the five input ports (N, S, E, W, local) and locks the grant for a whole packet, from head flit to tail flit. Its 3-bit grant index drives the crossbar select register directly, loaded on each grant change. Fairness is round-robin, and the search pointer advances past the last winner on each packet release.

## Interface
Parameters:
- NUM_REQ, 5: number of requesting input ports; 2..8 legal.
- IDX_W, 3: width of grant index; must satisfy 2^IDX_W >= NUM_REQ.
- TIMEOUT, 16: stall-cycle limit for lock release. Used only with ARB_TIMEOUT_EN.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset; rst synchronous, active-high.
- req_i, input, NUM_REQ: requester i has a flit waiting for this output.
- tail_i, input, NUM_REQ: the waiting flit of requester i is a tail flit. It is qualified by req_i[i].
- out_ready_i, input, 1: downstream has a credit or buffer slot this cycle.
- grant_o, output, NUM_REQ: one-hot grant, registered.
- grant_idx_o, output, IDX_W: binary index of the granted requester, registered. This is the crossbar select.
- grant_valid_o, output, 1: a grant is held (state LOCKED).
- fire_o, output, 1: combinational transfer strobe, equal to grant_valid_o & out_ready_i & req_i[grant_idx_o].
- timeout_o, output, 1: one-cycle pulse when a lock is force-released. Tied 0 without ARB_TIMEOUT_EN.

## Operation
State machine:
- States: IDLE and LOCKED. Reset state is IDLE.
- IDLE, with req_i nonzero:
  - Choose the first set req_i[k], searching k = ptr, ptr+1, …, modulo NUM_REQ.
  - Register grant_o = 1<<k and grant_idx_o = k.
  - Move to LOCKED.
- IDLE, with req_i all zero: stay in IDLE. Outputs and ptr are unchanged.
- LOCKED:
  - The grant is held regardless of other requests.
  - Each cycle with fire_o = 1 transfers one flit.
  - If fire_o & tail_i[grant_idx_o]: go to IDLE, clear grant_o and grant_valid_o, and set ptr = (grant_idx_o+1) mod NUM_REQ.

Hold rules:
- grant_idx_o holds its value in IDLE, so the crossbar select stays stable.
- A granted requester deasserting req_i mid-packet does not release the lock. The lock is held until its tail fires or a timeout occurs.
- out_ready_i = 0 stalls transfer. fire_o = 0 and the state is held.

Pointer:
- ptr is IDX_W bits, reset 0.
- It wraps from NUM_REQ-1 to 0.
- It changes only on release.
- Single-flit packets (head = tail) release in the first fire cycle.

Reset:
- Reset mid-packet forces IDLE, ptr = 0, and all outputs 0 on the next edge. There is no partial-packet recovery.

## Timing
Reset values:
- grant_o = 0, grant_idx_o = 0, grant_valid_o = 0, timeout_o = 0.
- ptr = 0, timeout counter = 0.

Latency:
- A request seen in IDLE at edge n gives grant_valid_o = 1 after edge n. The first possible fire_o is in cycle n+1.
- fire_o is same-cycle combinational from req_i and out_ready_i.

Release and re-arbitration:
- The release edge returns the block to IDLE.
- Re-arbitration takes one more edge, so there is one bubble cycle between packets on the same output.

Simultaneous events:
- The tail fire and a new request from any port in the same cycle: release happens first, and the new request is arbitrated in the following IDLE cycle.

## Configuration
ARB_TIMEOUT_EN

Defined:
- A counter of width clog2(TIMEOUT+1) increments each LOCKED cycle in which req_i[grant_idx_o] = 0. It clears on any cycle where that request is 1, and on release.
- When the counter reaches TIMEOUT, the next edge forces IDLE and advances ptr as on release. timeout_o pulses high for exactly that one cycle.

Undefined:
- No counter exists and timeout_o is constant 0.
- A lock is released only by a tail fire or by reset.

## Test plan
- Basic grant: reset, then req_i = 5'b00100 with tail_i = 5'b00100 and out_ready_i = 1.
  - Grant: grant_idx_o = 2 one cycle later; fire_o is high that cycle.
  - Release: grant_valid_o drops the next cycle and ptr = 3.
- Round-robin order: req_i = 5'b11111 held, every packet one flit, out_ready_i = 1.
  - Grant order is 0, 1, 2, 3, 4, 0.
  - Each grant is separated by one idle cycle.
- Packet lock: requester 1 sends a 4-flit packet (tail on the 4th) while req_i[3] is also asserted.
  - grant_idx_o stays 1 for all 4 fires; 3 is granted only after release.
- Backpressure: lock on 0 with out_ready_i = 0 for 5 cycles, then 1.
  - fire_o = 0 during the stall and grant is held.
  - The tail fires on the first ready cycle.
- Reset mid-packet: rst asserted while LOCKED on 4 after 2 flits.
  - Next cycle: all outputs 0 and ptr = 0.
  - A subsequent req_i = 5'b10001 grants index 0.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT = 16): lock on 2, then req_i[2] drops for 16 cycles.
  - timeout_o pulses once, the lock is released, and ptr = 3.
  - Without the macro, the lock holds indefinitely and timeout_o stays 0.

Source files
------------

// File: rtl/noc_out_arbiter_if.sv
// Handshake bundle between the five router input ports and one output-port arbiter.
// The arbiter side uses the slave modport.
interface noc_out_arbiter_if #(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned IDX_W   = 3
);
    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] tail_i;
    logic               out_ready_i;
    logic [NUM_REQ-1:0] grant_o;
    logic [IDX_W-1:0]   grant_idx_o;
    logic               grant_valid_o;
    logic               fire_o;
    logic               timeout_o;

    modport master (
        output req_i, tail_i, out_ready_i,
        input  grant_o, grant_idx_o, grant_valid_o, fire_o, timeout_o
    );

    modport slave (
        input  req_i, tail_i, out_ready_i,
        output grant_o, grant_idx_o, grant_valid_o, fire_o, timeout_o
    );
endinterface

// File: rtl/noc_out_arbiter.sv
// Round-robin, packet-locked arbiter for one NoC router output port.
// Define ARB_TIMEOUT_EN to force-release a lock whose owner stops requesting for TIMEOUT cycles.
module noc_out_arbiter #(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    noc_out_arbiter_if.slave bus
);
    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << IDX_W) < NUM_REQ || TIMEOUT == 0) begin : g_bad_cfg
        $error("noc_out_arbiter: illegal parameter combination");
    end

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [IDX_W-1:0]   r_grant_idx, w_grant_idx_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic               r_timeout, w_timeout_nxt;
    logic [IDX_W-1:0]   w_win_idx, w_idx_inc;
    logic               w_fire, w_tail_rel, w_to_hit;

    // Walking the ring backwards lets the last hit be the first requester at or after ptr.
    function automatic logic [IDX_W-1:0] first_from(input logic [NUM_REQ-1:0] req,
                                                     input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] k;
        first_from = '0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            k = IDX_W'((32'(ptr) + i - 1) % NUM_REQ);
            if (req[k]) first_from = k;
        end
    endfunction

    always_comb begin
        w_win_idx  = first_from(bus.req_i, r_ptr);
        w_idx_inc  = (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_idx + 1'b1;
        w_fire     = (r_state == LOCKED) & bus.out_ready_i & bus.req_i[r_grant_idx];
        w_tail_rel = w_fire & bus.tail_i[r_grant_idx];
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_stall_cnt;

    assign w_to_hit = (r_state == LOCKED) && (r_stall_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_state != LOCKED || w_tail_rel || w_to_hit || bus.req_i[r_grant_idx]) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_grant_idx_nxt = r_grant_idx;
        w_ptr_nxt       = r_ptr;
        w_timeout_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (|bus.req_i) begin
                    w_state_nxt     = LOCKED;
                    w_grant_nxt     = NUM_REQ'(1) << w_win_idx;
                    w_grant_idx_nxt = w_win_idx;
                end
            end
            LOCKED: begin
                // A tail release wins over a coincident timeout, so no pulse is raised then.
                if (w_tail_rel || w_to_hit) begin
                    w_state_nxt   = IDLE;
                    w_grant_nxt   = '0;
                    w_ptr_nxt     = w_idx_inc;
                    w_timeout_nxt = ~w_tail_rel;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_ptr       <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_ptr       <= w_ptr_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign bus.grant_o       = r_grant;
    assign bus.grant_idx_o   = r_grant_idx;
    assign bus.grant_valid_o = (r_state == LOCKED);
    assign bus.fire_o        = w_fire;
    assign bus.timeout_o     = r_timeout;
endmodule

// File: tb/tb_noc_out_arbiter.sv
// Randomized and directed bench for noc_out_arbiter against a packet-level reference model.
// The model honours ARB_TIMEOUT_EN the same way the design build does.
module tb_noc_out_arbiter;
    localparam int N  = 5;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_out_arbiter_if #(.NUM_REQ(N), .IDX_W(3)) bus ();

    noc_out_arbiter #(.NUM_REQ(N), .IDX_W(3), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference: who owns the port, where the next search starts, how long the owner has been silent.
    bit m_locked;
    int m_owner;
    int m_ptr;
    int m_stall;
    bit m_to;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] tail,
                              input logic rdy, input logic r);
        bit fire;
        if (r) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_stall = 0; m_to = 0;
            return;
        end
        m_to = 0;
        if (!m_locked) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (req[k]) begin
                    m_locked = 1; m_owner = k; m_stall = 0;
                    break;
                end
            end
        end else begin
            fire = rdy && req[m_owner];
            if (fire && tail[m_owner]) begin
                m_locked = 0; m_ptr = (m_owner + 1) % N; m_stall = 0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_stall == TO) begin
                m_locked = 0; m_ptr = (m_owner + 1) % N; m_stall = 0; m_to = 1;
            end else if (req[m_owner]) begin
                m_stall = 0;
            end else begin
                m_stall++;
            end
`endif
        end
    endtask

    // Drive one cycle's inputs, compare all outputs mid-cycle, then advance the model past the edge.
    task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] tail,
                         input logic rdy, input logic r);
        logic [N-1:0] exp_grant;
        @(negedge clk);
        bus.req_i = req; bus.tail_i = tail; bus.out_ready_i = rdy; rst = r;
        #1;
        exp_grant = m_locked ? N'(1) << m_owner : '0;
        check("grant",   32'(bus.grant_o),       32'(exp_grant));
        check("idx",     32'(bus.grant_idx_o),   32'(m_owner));
        check("valid",   32'(bus.grant_valid_o), 32'(m_locked));
        check("fire",    32'(bus.fire_o),        32'(m_locked && rdy && req[m_owner]));
        check("timeout", 32'(bus.timeout_o),     32'(m_to));
        model_step(req, tail, rdy, r);
    endtask

    initial begin
        int q_rr[$];
        int n_pulse;
        logic [N-1:0] rq, tl;
        logic rdy, rr;

        rst = 1'b1;
        bus.req_i = '0; bus.tail_i = '0; bus.out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        model_step('0, '0, 1'b0, 1'b1);

        // Basic grant and release, then confirm the pointer moved to 3.
        cycle(5'b00000, 5'b00000, 1'b1, 1'b0);
        cycle(5'b00100, 5'b00100, 1'b1, 1'b0);
        cycle(5'b00100, 5'b00100, 1'b1, 1'b0);
        check("basic_idx",  32'(bus.grant_idx_o), 32'd2);
        check("basic_fire", 32'(bus.fire_o),      32'd1);
        cycle(5'b00000, 5'b00000, 1'b1, 1'b0);
        check("basic_rel", 32'(bus.grant_valid_o), 32'd0);
        cycle(5'b01001, 5'b01001, 1'b1, 1'b0);
        cycle(5'b00000, 5'b01001, 1'b1, 1'b0);
        check("basic_ptr", 32'(bus.grant_idx_o), 32'd3);

        // Round-robin over single-flit packets from all ports.
        cycle('0, '0, 1'b1, 1'b1);
        for (int c = 0; c < 12; c++) begin
            cycle(5'b11111, 5'b11111, 1'b1, 1'b0);
            if (bus.grant_valid_o) q_rr.push_back(int'(bus.grant_idx_o));
        end
        check("rr_count", 32'(q_rr.size()), 32'd6);
        for (int i = 0; i < q_rr.size() && i < 6; i++) check("rr_order", 32'(q_rr[i]), 32'(i % 5));

        // Four-flit packet from port 1 holds the lock against port 3.
        cycle('0, '0, 1'b1, 1'b1);
        cycle(5'b01010, 5'b00000, 1'b1, 1'b0);
        for (int f = 0; f < 4; f++) begin
            cycle(5'b01010, (f == 3) ? 5'b00010 : 5'b00000, 1'b1, 1'b0);
            check("lock_idx", 32'(bus.grant_idx_o), 32'd1);
        end
        cycle(5'b01000, 5'b00000, 1'b1, 1'b0);
        cycle(5'b01000, 5'b00000, 1'b1, 1'b0);
        check("lock_next", 32'(bus.grant_idx_o), 32'd3);

        // Backpressure on port 0.
        cycle('0, '0, 1'b1, 1'b1);
        cycle(5'b00001, 5'b00001, 1'b0, 1'b0);
        for (int s = 0; s < 5; s++) begin
            cycle(5'b00001, 5'b00001, 1'b0, 1'b0);
            check("bp_stall", 32'(bus.fire_o), 32'd0);
        end
        cycle(5'b00001, 5'b00001, 1'b1, 1'b0);
        check("bp_fire", 32'(bus.fire_o), 32'd1);
        cycle(5'b00000, 5'b00000, 1'b1, 1'b0);

        // Reset while locked on port 4 after two flits.
        cycle('0, '0, 1'b1, 1'b1);
        cycle(5'b00000, 5'b00000, 1'b1, 1'b0);
        cycle(5'b10000, 5'b00000, 1'b1, 1'b0);
        cycle(5'b10000, 5'b00000, 1'b1, 1'b0);
        cycle(5'b10000, 5'b00000, 1'b1, 1'b0);
        cycle(5'b10000, 5'b00000, 1'b1, 1'b1);
        cycle(5'b10001, 5'b00000, 1'b1, 1'b0);
        check("rst_idx", 32'(bus.grant_idx_o), 32'd0);
        cycle(5'b10001, 5'b00000, 1'b1, 1'b0);
        check("rst_regrant", 32'(bus.grant_idx_o), 32'd0);

        // Owner of port 2 goes silent.
        cycle('0, '0, 1'b1, 1'b1);
        cycle(5'b00100, 5'b00000, 1'b1, 1'b0);
        n_pulse = 0;
        for (int s = 0; s < 20; s++) begin
            cycle(5'b00000, 5'b00000, 1'b1, 1'b0);
            if (bus.timeout_o) n_pulse++;
        end
`ifdef ARB_TIMEOUT_EN
        check("to_pulses", 32'(n_pulse), 32'd1);
        check("to_valid",  32'(bus.grant_valid_o), 32'd0);
        cycle(5'b01001, 5'b00000, 1'b1, 1'b0);
        cycle(5'b01001, 5'b00000, 1'b1, 1'b0);
        check("to_ptr", 32'(bus.grant_idx_o), 32'd3);
`else
        check("to_pulses", 32'(n_pulse), 32'd0);
        check("to_valid",  32'(bus.grant_valid_o), 32'd1);
`endif

        // Random traffic with occasional resets.
        cycle('0, '0, 1'b1, 1'b1);
        for (int c = 0; c < 600; c++) begin
            rq  = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
            tl  = N'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            rr  = ($urandom_range(0, 99) == 0);
            cycle(rq, tl, rdy, rr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
